// File: rtl/outport_arbiter.sv
// Output-port arbiter: round-robin grant in IDLE, packet lock in LOCKED, per-VC credit counters.
// Optional OUTPORT_ARBITER_CREDIT_CHECK_EN adds a sticky credit_err output for saturated credit returns.
module outport_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8,
    localparam int VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int CW   = $clog2(BUFFER_SIZE + 1),
    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*VC_W-1:0] req_vc,
    input  logic [NUM_REQ-1:0]      req_tail,
    input  logic [NUM_VCS-1:0]      credit_granted,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    packet_sent,
    output logic [VC_W-1:0]         sent_vc,
    output logic [NUM_VCS*CW-1:0]   credits,
`ifdef OUTPORT_ARBITER_CREDIT_CHECK_EN
    output logic                    credit_err,
`endif
    output logic                    busy
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                        state_q, state_d;
    logic [RR_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [RR_W-1:0]               owner_q, owner_d;
    logic [VC_W-1:0]               lock_vc_q, lock_vc_d;
    logic [NUM_VCS-1:0][CW-1:0]    credit_q, credit_d;

    logic [VC_W-1:0]               req_vc_a [NUM_REQ];
    logic [NUM_REQ-1:0]            eligible;
    logic                          win_found;
    logic [RR_W-1:0]               win_idx;
    logic [NUM_REQ-1:0]            grant_c;
    logic                          send_c;
    logic [VC_W-1:0]               sent_vc_c;

    function automatic logic [RR_W-1:0] next_idx(input logic [RR_W-1:0] i);
        if (int'(i) == NUM_REQ - 1) return '0;
        return i + 1'b1;
    endfunction

    // A requester is eligible only if its VC is real and that VC still has downstream space.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vc_a[i] = req_vc[i*VC_W +: VC_W];
            eligible[i] = req[i] && (int'(req_vc_a[i]) < NUM_VCS) && (credit_q[req_vc_a[i]] != '0);
        end
    end

    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = RR_W'(idx);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        lock_vc_d = lock_vc_q;
        grant_c   = '0;
        send_c    = 1'b0;
        sent_vc_c = '0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_c[win_idx] = 1'b1;
                    send_c           = 1'b1;
                    sent_vc_c        = req_vc_a[win_idx];
                    if (req_tail[win_idx]) begin
                        rr_ptr_d = next_idx(win_idx);
                    end else begin
                        state_d   = LOCKED;
                        owner_d   = win_idx;
                        lock_vc_d = req_vc_a[win_idx];
                    end
                end
            end
            LOCKED: begin
                grant_c[owner_q] = 1'b1;
                sent_vc_c        = lock_vc_q;
                if (req[owner_q] && credit_q[lock_vc_q] != '0) begin
                    send_c = 1'b1;
                    if (req_tail[owner_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_idx(owner_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef OUTPORT_ARBITER_CREDIT_CHECK_EN
    logic credit_err_q, credit_err_d;
    logic sat_ret;
`endif

    // Send and return on the same VC cancel; a lone return at full depth saturates.
    always_comb begin
        credit_d = credit_q;
`ifdef OUTPORT_ARBITER_CREDIT_CHECK_EN
        sat_ret  = 1'b0;
`endif
        for (int v = 0; v < NUM_VCS; v++) begin
            if (credit_granted[v] && !(send_c && sent_vc_c == VC_W'(v))) begin
                if (credit_q[v] == CW'(BUFFER_SIZE)) begin
`ifdef OUTPORT_ARBITER_CREDIT_CHECK_EN
                    sat_ret = 1'b1;
`endif
                end else begin
                    credit_d[v] = credit_q[v] + 1'b1;
                end
            end else if (!credit_granted[v] && send_c && sent_vc_c == VC_W'(v)) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end
        end
    end

`ifdef OUTPORT_ARBITER_CREDIT_CHECK_EN
    // credit_granted carries one bit per existing VC, so an out-of-range return cannot be encoded.
    assign credit_err_d = credit_err_q | sat_ret;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) credit_err_q <= 1'b0;
        else        credit_err_q <= credit_err_d;
    end

    assign credit_err = credit_err_q;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!n_rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            lock_vc_q <= '0;
            credit_q  <= {NUM_VCS{CW'(BUFFER_SIZE)}};
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            lock_vc_q <= lock_vc_d;
            credit_q  <= credit_d;
        end
    end

    // The IDLE grant is combinational, so it must be masked explicitly while reset is held.
    assign grant       = n_rst ? grant_c : '0;
    assign packet_sent = n_rst & send_c;
    assign sent_vc     = n_rst ? sent_vc_c : '0;
    assign credits     = credit_q;
    assign busy        = (state_q == LOCKED);

endmodule

// File: tb/tb_outport_arbiter.sv
// Scoreboard bench for outport_arbiter: a packet-level reference model queues the expected outputs per cycle,
// a monitor pops and compares; directed scenarios add constant checks. Honours OUTPORT_ARBITER_CREDIT_CHECK_EN.
module tb_outport_arbiter;

    localparam int N  = 3;
    localparam int V  = 2;
    localparam int B  = 8;
    localparam int VW = 1;
    localparam int CW = 4;

    typedef struct packed {
        logic [N-1:0]    grant;
        logic            sent;
        logic [VW-1:0]   svc;
        logic            chk_svc;
        logic [V*CW-1:0] credits;
        logic            busy;
        logic            err;
    } exp_t;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*VW-1:0] req_vc = '0;
    logic [N-1:0]    req_tail = '0;
    logic [V-1:0]    credit_granted = '0;
    logic [N-1:0]    grant;
    logic            packet_sent;
    logic [VW-1:0]   sent_vc;
    logic [V*CW-1:0] credits;
    logic            busy;
    logic            err_obs;

    outport_arbiter #(.NUM_REQ(N), .NUM_VCS(V), .BUFFER_SIZE(B)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .req            (req),
        .req_vc         (req_vc),
        .req_tail       (req_tail),
        .credit_granted (credit_granted),
        .grant          (grant),
        .packet_sent    (packet_sent),
        .sent_vc        (sent_vc),
        .credits        (credits),
`ifdef OUTPORT_ARBITER_CREDIT_CHECK_EN
        .credit_err     (err_obs),
`endif
        .busy           (busy)
    );

`ifndef OUTPORT_ARBITER_CREDIT_CHECK_EN
    assign err_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb [$];

    // Reference model: packet-level view of the port.
    bit m_locked;
    int m_owner, m_lvc, m_rr;
    int m_cred [V];
    bit m_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_lvc    = 0;
        m_rr     = 0;
        m_err    = 1'b0;
        for (int v = 0; v < V; v++) m_cred[v] = B;
    endtask

    task automatic model_cycle();
        exp_t e;
        int   who, wvc, i;
        e   = '0;
        who = -1;
        wvc = 0;
        if (!n_rst) begin
            model_reset();
            for (int v = 0; v < V; v++) e.credits[v*CW +: CW] = CW'(B);
            e.chk_svc = 1'b1;
            sb.push_back(e);
            return;
        end
        for (int v = 0; v < V; v++) e.credits[v*CW +: CW] = CW'(m_cred[v]);
        e.busy = m_locked;
        e.err  = m_err;
        if (m_locked) begin
            e.grant[m_owner] = 1'b1;
            if (req[m_owner] && m_cred[m_lvc] > 0) begin
                who = m_owner;
                wvc = m_lvc;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                i = (m_rr + k) % N;
                if (who < 0 && req[i] && m_cred[int'(req_vc[i*VW +: VW])] > 0) begin
                    who = i;
                    wvc = int'(req_vc[i*VW +: VW]);
                end
            end
            if (who >= 0) e.grant[who] = 1'b1;
        end
        e.sent    = (who >= 0);
        e.svc     = VW'(wvc);
        e.chk_svc = (who >= 0);
        for (int v = 0; v < V; v++) begin
            if (e.sent && wvc == v && !credit_granted[v]) m_cred[v]--;
            else if (credit_granted[v] && !(e.sent && wvc == v)) begin
                if (m_cred[v] == B) m_err = 1'b1;
                else m_cred[v]++;
            end
        end
        if (who >= 0) begin
            if (req_tail[who]) begin
                m_locked = 1'b0;
                m_rr     = (who + 1) % N;
            end else if (!m_locked) begin
                m_locked = 1'b1;
                m_owner  = who;
                m_lvc    = wvc;
            end
        end
        sb.push_back(e);
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic [N*VW-1:0] v, input logic [N-1:0] t,
                       input logic [V-1:0] cg);
        @(negedge clk);
        n_rst          = 1'b1;
        req            = r;
        req_vc         = v;
        req_tail       = t;
        credit_granted = cg;
        model_cycle();
    endtask

    task automatic rst_cyc(input logic [N-1:0] r);
        @(negedge clk);
        n_rst          = 1'b0;
        req            = r;
        req_vc         = '0;
        req_tail       = '0;
        credit_granted = '0;
        model_cycle();
    endtask

    task automatic do_reset();
        rst_cyc(3'b111);
        rst_cyc(3'b111);
    endtask

    // Monitor: compares every DUT output against the oldest queued expectation.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                ok = (grant === e.grant) && (packet_sent === e.sent) && (credits === e.credits) &&
                     (busy === e.busy) && (!e.chk_svc || sent_vc === e.svc);
`ifdef OUTPORT_ARBITER_CREDIT_CHECK_EN
                ok = ok && (err_obs === e.err);
`endif
                n_cmp++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL sb t=%0t: got grant=%b sent=%b vc=%0d cred=%h busy=%b err=%b, want grant=%b sent=%b vc=%0d cred=%h busy=%b err=%b",
                             $time, grant, packet_sent, sent_vc, credits, busy, err_obs,
                             e.grant, e.sent, e.svc, e.credits, e.busy, e.err);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] fair_seq [4];
        fair_seq[0] = 3'b001;
        fair_seq[1] = 3'b010;
        fair_seq[2] = 3'b100;
        fair_seq[3] = 3'b001;
        model_reset();
        do_reset();

        // Fairness: all tail, VC0, credit returned every cycle.
        for (int k = 0; k < 4; k++) begin
            cyc(3'b111, 3'b000, 3'b111, 2'b01);
            #2 check($sformatf("fair_grant%0d", k), 32'(grant), 32'(fair_seq[k]));
        end

        // Packet lock: req0 sends 3 flits on VC1 while req1 keeps requesting.
        do_reset();
        cyc(3'b011, 3'b001, 3'b000, 2'b00);
        #2 check("lock_g1", 32'(grant), 32'b001);
        check("lock_busy1", 32'(busy), 0);
        cyc(3'b011, 3'b001, 3'b000, 2'b00);
        #2 check("lock_g2", 32'(grant), 32'b001);
        check("lock_busy2", 32'(busy), 1);
        cyc(3'b011, 3'b001, 3'b001, 2'b00);
        #2 check("lock_g3", 32'(grant), 32'b001);
        check("lock_busy3", 32'(busy), 1);
        cyc(3'b010, 3'b000, 3'b010, 2'b00);
        #2 check("lock_g4", 32'(grant), 32'b010);
        check("lock_busy4", 32'(busy), 0);

        // Credit exhaustion on VC0, then one return.
        do_reset();
        for (int k = 0; k < B; k++) cyc(3'b001, 3'b000, 3'b001, 2'b00);
        cyc(3'b001, 3'b000, 3'b001, 2'b00);
        #2 check("exh_cred0", 32'(credits[CW-1:0]), 0);
        check("exh_sent", 32'(packet_sent), 0);
        check("exh_grant", 32'(grant), 0);
        cyc(3'b001, 3'b000, 3'b001, 2'b01);
        #2 check("exh_ret_sent", 32'(packet_sent), 0);
        cyc(3'b001, 3'b000, 3'b001, 2'b00);
        #2 check("exh_resume_sent", 32'(packet_sent), 1);
        check("exh_resume_grant", 32'(grant), 32'b001);

        // Simultaneous send and return on VC1 at credits[1]=5.
        do_reset();
        for (int k = 0; k < 3; k++) cyc(3'b001, 3'b001, 3'b001, 2'b00);
        cyc(3'b001, 3'b001, 3'b001, 2'b10);
        #2 check("sim_pre", 32'(credits[2*CW-1:CW]), 5);
        check("sim_sent", 32'(packet_sent), 1);
        cyc(3'b000, 3'b000, 3'b000, 2'b00);
        #2 check("sim_post", 32'(credits[2*CW-1:CW]), 5);

        // Reset while locked on owner 2.
        do_reset();
        cyc(3'b100, 3'b100, 3'b000, 2'b00);
        cyc(3'b100, 3'b100, 3'b000, 2'b00);
        #2 check("rmid_busy", 32'(busy), 1);
        check("rmid_grant", 32'(grant), 32'b100);
        rst_cyc(3'b111);
        #2 check("rmid_rst_grant", 32'(grant), 0);
        check("rmid_rst_busy", 32'(busy), 0);
        check("rmid_rst_sent", 32'(packet_sent), 0);
        cyc(3'b111, 3'b000, 3'b111, 2'b00);
        #2 check("rmid_grant0", 32'(grant), 32'b001);
        check("rmid_cred", 32'(credits), 32'h88);
        check("rmid_busy_after", 32'(busy), 0);

`ifdef OUTPORT_ARBITER_CREDIT_CHECK_EN
        // Saturated return raises the sticky error.
        do_reset();
        cyc(3'b000, 3'b000, 3'b000, 2'b01);
        cyc(3'b000, 3'b000, 3'b000, 2'b00);
        #2 check("err_cred0", 32'(credits[CW-1:0]), 8);
        check("err_set", 32'(err_obs), 1);
        for (int k = 0; k < 3; k++) cyc(3'b000, 3'b000, 3'b000, 2'b00);
        #2 check("err_sticky", 32'(err_obs), 1);
        rst_cyc(3'b000);
        #2 check("err_clr", 32'(err_obs), 0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                rst_cyc(N'($urandom));
            end else begin
                cyc(N'($urandom), N'($urandom),
                    {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
                    {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
            end
        end

        @(negedge clk);
        #4;
        check("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
